flexcounter_bank: RTL and testbench
===================================

Name: flexcounter_bank

Overview:
- Parametrised multi-channel successor to the single flex counter: NUM_CH independent counters sharing one clock and reset.
- Each channel has a run-time programmable terminal value, count direction, terminal mode (wrap / saturate / one-shot), synchronous load and clear.
- Provides a per-channel terminal strobe and done flag, plus aggregate outputs.
- Used as the timer/baud/tick generator bank feeding the UART and keyboard-scan blocks.

Parameters:
- NUM_CH, 4: number of independent channels (>=1).
- COUNTWIDTH, 8: width of every count, maxCount and loadValue field (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- syncClear  in  1  clears all channels together; overrides every per-channel control.
- enable  in  NUM_CH  per-channel count enable.
- clear  in  NUM_CH  per-channel synchronous clear.
- load  in  NUM_CH  per-channel synchronous load of loadValue.
- countDown  in  NUM_CH  per channel: 1 = count down, 0 = count up.
- mode  in  2*NUM_CH  per channel: 00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (treated as wrap).
- maxCount  in  COUNTWIDTH*NUM_CH  per-channel terminal value; channel i occupies bits [i*W +: W].
- loadValue  in  COUNTWIDTH*NUM_CH  per-channel load data, same packing as maxCount.
- count  out  COUNTWIDTH*NUM_CH  per-channel registered count.
- strobe  out  NUM_CH  one-cycle pulse when the channel reaches its terminal.
- done  out  NUM_CH  sticky flag; set on terminal in saturate and one-shot modes.
- anyStrobe  out  1  registered OR of all next-cycle strobe values, aligned with strobe.

Behaviour:
- RST high (asynchronous) sets all outputs to 0: count, strobe, done, anyStrobe. Every channel's internal armed flag is set to 1.
- All channels are independent and evaluated identically in the same cycle. All outputs are registered, with no combinational input-to-output path.
- Per-channel priority, highest first: syncClear, clear, load, counting step.
  - syncClear or clear: count=0, done=0, armed=1, strobe=0.
  - load: count=loadValue, done=0, armed=1, strobe=0. No strobe even if loadValue equals the terminal.
- Terminal value: maxCount when counting up; 0 when counting down.
  - Restart value: 0 when counting up; maxCount when counting down.
- A step occurs only when enable=1, armed=1 and no clear/load is active. When enable=0, count holds and strobe=0.
- Up step:
  - count < maxCount: count+1.
  - count >= maxCount (at terminal, or maxCount moved below count): apply the mode's at-terminal rule.
- Down step:
  - count > 0 and count <= maxCount: count-1.
  - count > maxCount: load maxCount, no strobe.
  - count == 0: apply the mode's at-terminal rule.
- At-terminal rules:
  - Wrap: count = restart value.
  - Saturate: count holds.
  - One-shot: unreachable, because the channel disarms on reaching terminal.
- Strobe: registered; strobe[i]=1 on the same edge where a step makes next count equal the terminal value. It is therefore high during the first cycle count shows the terminal value.
  - Wrap mode with maxCount=0: every enabled step produces the terminal, so strobe stays high continuously while enabled.
  - Saturate mode: strobe fires once on arrival; holding at terminal does not re-strobe.
- done:
  - Saturate: set with the arrival strobe; stays set until clear, syncClear or load.
  - One-shot: set with the arrival strobe and armed cleared. Count freezes at terminal, ignoring enable, until clear, syncClear or load.
  - Wrap: never set.
- Mode or countDown changes mid-run take effect on the next step. No other state is reset.
- All arithmetic is unsigned COUNTWIDTH. Count never leaves [0, 2^W-1], and there is no overflow path because the terminal check precedes increment.
- Reset asserted mid-operation clears immediately. After reset deasserts, counting resumes from 0 on the first enabled edge.

Test Plan:
- W=8, ch0 wrap/up, maxCount=3, enable held high: count 0,1,2,3,0,1…; strobe high exactly in cycles where count==3; anyStrobe matches.
- ch1 down/wrap, loadValue=2, pulse load then enable: count 2,1,0,max(5),4…; strobe with count==0; ch1 load and enable in the same cycle → count=2, no step.
- ch2 saturate/up, maxCount=4: reaches 4, single strobe pulse, done=1, count stays 4; then clear → count 0, done 0.
- ch3 one-shot/up, maxCount=2: 0,1,2 then frozen with enable high, done=1; load 0 re-arms and counting repeats; maxCount lowered to 1 while count=3 in wrap mode → next step gives 0, no strobe.
- Simultaneous: all channels enabled, syncClear with load/clear asserted → all counts 0, no strobes; RST pulsed asynchronously mid-count → outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/flexcounter_bank.sv
// rtl/flexcounter_bank.sv - bank of independent programmable counters with terminal strobe and done flags
module flexcounter_bank #(
  parameter int NUM_CH     = 4,
  parameter int COUNTWIDTH = 8
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         syncClear,
  input  logic [NUM_CH-1:0]            enable,
  input  logic [NUM_CH-1:0]            clear,
  input  logic [NUM_CH-1:0]            load,
  input  logic [NUM_CH-1:0]            countDown,
  input  logic [2*NUM_CH-1:0]          mode,
  input  logic [COUNTWIDTH*NUM_CH-1:0] maxCount,
  input  logic [COUNTWIDTH*NUM_CH-1:0] loadValue,
  output logic [COUNTWIDTH*NUM_CH-1:0] count,
  output logic [NUM_CH-1:0]            strobe,
  output logic [NUM_CH-1:0]            done,
  output logic                         anyStrobe
);

  localparam int W = COUNTWIDTH;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  // Registered per-channel state
  logic [W-1:0]      count_q [NUM_CH];
  logic [NUM_CH-1:0] armed_q;

  // Next-state values
  logic [W-1:0]      count_n [NUM_CH];
  logic [NUM_CH-1:0] strobe_n;
  logic [NUM_CH-1:0] done_n;
  logic [NUM_CH-1:0] armed_n;

  // Unpacked views of the packed per-channel buses
  logic [W-1:0] max_v  [NUM_CH];
  logic [W-1:0] load_v [NUM_CH];
  logic [W-1:0] inc_v  [NUM_CH];
  logic [W-1:0] dec_v  [NUM_CH];
  mode_t        mode_v [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign max_v[g]          = maxCount[g*W +: W];
    assign load_v[g]         = loadValue[g*W +: W];
    assign mode_v[g]         = mode_t'(mode[2*g +: 2]);
    // inc/dec are only selected when they cannot wrap, so plain W-bit math is safe
    assign inc_v[g]          = count_q[g] + W'(1);
    assign dec_v[g]          = count_q[g] - W'(1);
    assign count[g*W +: W]   = count_q[g];
  end

  // Per-channel next state: syncClear > clear > load > counting step
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      count_n[i]  = count_q[i];
      strobe_n[i] = 1'b0;
      done_n[i]   = done[i];
      armed_n[i]  = armed_q[i];

      if (syncClear || clear[i]) begin
        count_n[i] = '0;
        done_n[i]  = 1'b0;
        armed_n[i] = 1'b1;
      end else if (load[i]) begin
        count_n[i] = load_v[i];
        done_n[i]  = 1'b0;
        armed_n[i] = 1'b1;
      end else if (enable[i] && armed_q[i]) begin
        if (!countDown[i]) begin
          if (count_q[i] < max_v[i]) begin
            count_n[i]  = inc_v[i];
            strobe_n[i] = (inc_v[i] == max_v[i]);
          end else if (mode_v[i] == MODE_WRAP || mode_v[i] == MODE_RSVD) begin
            // Restart at 0; this is the terminal only when maxCount is 0
            count_n[i]  = '0;
            strobe_n[i] = (max_v[i] == '0);
          end
        end else begin
          if (count_q[i] > max_v[i]) begin
            // maxCount moved below the count: snap back into range silently
            count_n[i] = max_v[i];
          end else if (count_q[i] != '0) begin
            count_n[i]  = dec_v[i];
            strobe_n[i] = (dec_v[i] == '0);
          end else if (mode_v[i] == MODE_WRAP || mode_v[i] == MODE_RSVD) begin
            count_n[i]  = max_v[i];
            strobe_n[i] = (max_v[i] == '0);
          end
        end

        // Arrival at terminal latches done; one-shot also disarms to freeze the count
        if (strobe_n[i] && (mode_v[i] == MODE_SAT || mode_v[i] == MODE_ONESHOT)) begin
          done_n[i] = 1'b1;
        end
        if (strobe_n[i] && mode_v[i] == MODE_ONESHOT) begin
          armed_n[i] = 1'b0;
        end
      end
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= '0;
      end
      armed_q   <= '1;
      strobe    <= '0;
      done      <= '0;
      anyStrobe <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= count_n[i];
      end
      armed_q   <= armed_n;
      strobe    <= strobe_n;
      done      <= done_n;
      anyStrobe <= |strobe_n;
    end
  end

endmodule

// File: tb/tb_flexcounter_bank.sv
// tb/tb_flexcounter_bank.sv - vector table and scoreboard bench for flexcounter_bank
module tb_flexcounter_bank;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             RST;
  logic             syncClear;
  logic [N-1:0]     enable;
  logic [N-1:0]     clear;
  logic [N-1:0]     load;
  logic [N-1:0]     countDown;
  logic [2*N-1:0]   mode;
  logic [W*N-1:0]   maxCount;
  logic [W*N-1:0]   loadValue;
  logic [W*N-1:0]   count;
  logic [N-1:0]     strobe;
  logic [N-1:0]     done;
  logic             anyStrobe;

  flexcounter_bank #(.NUM_CH(N), .COUNTWIDTH(W)) dut (
    .clk       (clk),
    .RST       (RST),
    .syncClear (syncClear),
    .enable    (enable),
    .clear     (clear),
    .load      (load),
    .countDown (countDown),
    .mode      (mode),
    .maxCount  (maxCount),
    .loadValue (loadValue),
    .count     (count),
    .strobe    (strobe),
    .done      (done),
    .anyStrobe (anyStrobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sync;
    logic [3:0]   en;
    logic [3:0]   clr;
    logic [3:0]   ld;
    logic [3:0]   dn;
    logic [7:0]   md;
    logic [31:0]  mx;
    logic [31:0]  lv;
    logic [31:0]  cnt;
    logic [3:0]   stb;
    logic [3:0]   dne;
    logic         any;
  } vec_t;

  typedef struct {
    logic [31:0] cnt;
    logic [3:0]  stb;
    logic [3:0]  dne;
    logic        any;
  } exp_t;

  localparam int NV = 25;
  vec_t tbl [NV];
  exp_t sb_q [$];

  int errors = 0;
  int checks = 0;

  function automatic vec_t mkv(input logic s, input logic [3:0] en, input logic [3:0] clr,
                               input logic [3:0] ld, input logic [3:0] dn, input logic [7:0] md,
                               input logic [31:0] mx, input logic [31:0] lv, input logic [31:0] cnt,
                               input logic [3:0] stb, input logic [3:0] dne, input logic any);
    vec_t v;
    v.sync = s;  v.en = en;  v.clr = clr; v.ld = ld;  v.dn = dn;  v.md = md;
    v.mx = mx;   v.lv = lv;  v.cnt = cnt; v.stb = stb; v.dne = dne; v.any = any;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    syncClear = v.sync;
    enable    = v.en;
    clear     = v.clr;
    load      = v.ld;
    countDown = v.dn;
    mode      = v.md;
    maxCount  = v.mx;
    loadValue = v.lv;
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " count"},     count,             e.cnt);
      chk({tag, " strobe"},    {28'd0, strobe},   {28'd0, e.stb});
      chk({tag, " done"},      {28'd0, done},     {28'd0, e.dne});
      chk({tag, " anyStrobe"}, {31'd0, anyStrobe}, {31'd0, e.any});
    end
  endtask

  // Modes: ch0 wrap, ch1 wrap (down), ch2 saturate, ch3 one-shot / later wrap
  localparam logic [7:0]  M0  = 8'h90;
  localparam logic [7:0]  M1  = 8'h10;
  localparam logic [3:0]  DN  = 4'b0010;
  localparam logic [31:0] MX0 = 32'h02040503;
  localparam logic [31:0] MX1 = 32'h05040503;
  localparam logic [31:0] MX2 = 32'h01040503;
  localparam logic [31:0] MX3 = 32'h01040500;
  localparam logic [31:0] LV0 = 32'h00000200;
  localparam logic [31:0] LV1 = 32'h00000900;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    vec_t rv;

    tbl[0]  = mkv(0, 4'h0, 4'h0, 4'h0, DN, M0, MX0, LV0, 32'h00000000, 4'b0000, 4'b0000, 0);
    tbl[1]  = mkv(0, 4'h2, 4'h0, 4'h2, DN, M0, MX0, LV0, 32'h00000200, 4'b0000, 4'b0000, 0);
    tbl[2]  = mkv(0, 4'hF, 4'h0, 4'h0, DN, M0, MX0, LV0, 32'h01010101, 4'b0000, 4'b0000, 0);
    tbl[3]  = mkv(0, 4'hF, 4'h0, 4'h0, DN, M0, MX0, LV0, 32'h02020002, 4'b1010, 4'b1000, 1);
    tbl[4]  = mkv(0, 4'hF, 4'h0, 4'h0, DN, M0, MX0, LV0, 32'h02030503, 4'b0001, 4'b1000, 1);
    tbl[5]  = mkv(0, 4'hF, 4'h0, 4'h0, DN, M0, MX0, LV0, 32'h02040400, 4'b0100, 4'b1100, 1);
    tbl[6]  = mkv(0, 4'hF, 4'h0, 4'h0, DN, M0, MX0, LV0, 32'h02040301, 4'b0000, 4'b1100, 0);
    tbl[7]  = mkv(0, 4'h0, 4'h0, 4'h0, DN, M0, MX0, LV0, 32'h02040301, 4'b0000, 4'b1100, 0);
    tbl[8]  = mkv(0, 4'hF, 4'h0, 4'h0, DN, M0, MX0, LV0, 32'h02040202, 4'b0000, 4'b1100, 0);
    tbl[9]  = mkv(0, 4'hF, 4'h4, 4'h0, DN, M0, MX0, LV0, 32'h02000103, 4'b0001, 4'b1000, 1);
    tbl[10] = mkv(0, 4'hF, 4'h0, 4'h8, DN, M0, MX0, LV0, 32'h00010000, 4'b0010, 4'b0000, 1);
    tbl[11] = mkv(0, 4'hF, 4'h0, 4'h0, DN, M0, MX0, LV0, 32'h01020501, 4'b0000, 4'b0000, 0);
    tbl[12] = mkv(0, 4'hF, 4'h0, 4'h0, DN, M0, MX0, LV0, 32'h02030402, 4'b1000, 4'b1000, 1);
    tbl[13] = mkv(1, 4'hF, 4'h5, 4'hF, DN, M0, MX0, LV0, 32'h00000000, 4'b0000, 4'b0000, 0);
    tbl[14] = mkv(0, 4'h8, 4'h0, 4'h0, DN, M1, MX1, LV0, 32'h01000000, 4'b0000, 4'b0000, 0);
    tbl[15] = mkv(0, 4'h8, 4'h0, 4'h0, DN, M1, MX1, LV0, 32'h02000000, 4'b0000, 4'b0000, 0);
    tbl[16] = mkv(0, 4'h8, 4'h0, 4'h0, DN, M1, MX1, LV0, 32'h03000000, 4'b0000, 4'b0000, 0);
    tbl[17] = mkv(0, 4'h8, 4'h0, 4'h0, DN, M1, MX2, LV0, 32'h00000000, 4'b0000, 4'b0000, 0);
    tbl[18] = mkv(0, 4'h8, 4'h0, 4'h0, DN, M1, MX2, LV0, 32'h01000000, 4'b1000, 4'b0000, 1);
    tbl[19] = mkv(0, 4'h0, 4'h0, 4'h2, DN, M1, MX2, LV1, 32'h01000900, 4'b0000, 4'b0000, 0);
    tbl[20] = mkv(0, 4'h2, 4'h0, 4'h0, DN, M1, MX2, LV1, 32'h01000500, 4'b0000, 4'b0000, 0);
    tbl[21] = mkv(0, 4'h2, 4'h0, 4'h0, DN, M1, MX2, LV1, 32'h01000400, 4'b0000, 4'b0000, 0);
    tbl[22] = mkv(0, 4'h1, 4'h0, 4'h0, DN, M1, MX3, LV1, 32'h01000400, 4'b0001, 4'b0000, 1);
    tbl[23] = mkv(0, 4'h1, 4'h0, 4'h0, DN, M1, MX3, LV1, 32'h01000400, 4'b0001, 4'b0000, 1);
    tbl[24] = mkv(0, 4'h0, 4'h0, 4'h0, DN, M1, MX3, LV1, 32'h01000400, 4'b0000, 4'b0000, 0);

    RST = 1'b1;
    apply(tbl[0]);
    #23;
    chk("reset count",     count,             32'h0);
    chk("reset strobe",    {28'd0, strobe},   32'h0);
    chk("reset done",      {28'd0, done},     32'h0);
    chk("reset anyStrobe", {31'd0, anyStrobe}, 32'h0);
    @(negedge clk);
    RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      e.cnt = tbl[i].cnt;
      e.stb = tbl[i].stb;
      e.dne = tbl[i].dne;
      e.any = tbl[i].any;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      compare_pop($sformatf("v%0d", i));
    end

    // Asynchronous reset in the middle of a clock period
    @(negedge clk);
    rv = mkv(0, 4'hF, 4'h0, 4'h0, DN, M0, MX0, LV0, 32'h0, 4'b0000, 4'b0000, 0);
    apply(rv);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre-reset ch0 count", {24'd0, count[7:0]}, 32'd2);
    #2;
    RST = 1'b1;
    #1;
    chk("async reset count",     count,             32'h0);
    chk("async reset strobe",    {28'd0, strobe},   32'h0);
    chk("async reset done",      {28'd0, done},     32'h0);
    chk("async reset anyStrobe", {31'd0, anyStrobe}, 32'h0);
    @(negedge clk);
    RST = 1'b0;
    e.cnt = 32'h01010501;
    e.stb = 4'b0000;
    e.dne = 4'b0000;
    e.any = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_pop("post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
